// File: rtl/star_row_mapper_if.sv
// Bundle between the scan FSM / pixel RAM side (master) and the row mapper (slave).
// Carries start pulse, seed coordinates, RAM read port and the mapping result.
interface star_row_mapper_if;
  logic       goMapRows;
  logic [2:0] xStart;
  logic [2:0] yStart;
  logic [2:0] pixVal;
  logic [5:0] rdAddr;
  logic [2:0] yTop;
  logic [2:0] yBottom;
  logic       topBottomFound;
  logic       busy;
`ifdef STAR_HEIGHT_EN
  logic [2:0] starHeight;

  modport master (
    output goMapRows, xStart, yStart, pixVal,
    input  rdAddr, yTop, yBottom,
    input  topBottomFound, busy, starHeight
  );

  modport slave (
    input  goMapRows, xStart, yStart, pixVal,
    output rdAddr, yTop, yBottom,
    output topBottomFound, busy, starHeight
  );
`else
  modport master (
    output goMapRows, xStart, yStart, pixVal,
    input  rdAddr, yTop, yBottom,
    input  topBottomFound, busy
  );

  modport slave (
    input  goMapRows, xStart, yStart, pixVal,
    output rdAddr, yTop, yBottom,
    output topBottomFound, busy
  );
`endif
endinterface

// File: rtl/star_row_mapper.sv
// Star row mapper: from a lit seed pixel, walks up then down its column
// to find the contiguous lit span. Ports: clk, resetn (async, active-low),
// bus (slave): goMapRows/xStart/yStart in, rdAddr out / pixVal in (1-cycle
// RAM latency), yTop/yBottom/topBottomFound/busy out.
// Optional macro STAR_HEIGHT_EN adds bus.starHeight = yBottom-yTop+1.
module star_row_mapper #(
  parameter int THRESHOLD = 0,
  parameter int MAX_X     = 6,
  parameter int MAX_Y     = 6
) (
  input logic              clk,
  input logic              resetn,
  star_row_mapper_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, UP_RD, UP_CHK, DN_RD, DN_CHK, DONE
  } state_t;

  localparam logic [2:0] TH    = 3'(THRESHOLD);
  localparam logic [2:0] YLAST = 3'(MAX_Y - 1);
  localparam logic [3:0] XLIM  = 4'(MAX_X);
  localparam logic [3:0] YLIM  = 4'(MAX_Y);

  state_t     state, stateNext;
  logic [2:0] xLat, xNext;
  logic [2:0] yTop, yTopNext;
  logic [2:0] yBot, yBotNext;
  logic [2:0] decTop, incBot;
  logic [2:0] probeY;
  logic [5:0] rowAddr;
  logic       lit, badSeed, found;

  assign lit     = bus.pixVal > TH;
  assign decTop  = yTop - 3'd1;
  assign incBot  = yBot + 3'd1;
  assign badSeed = ({1'b0, bus.xStart} >= XLIM) ||
                   ({1'b0, bus.yStart} >= YLIM);

  // Going down from a bottom-edge row has nothing to probe.
  function automatic state_t downEntry(input logic [2:0] yb);
    return (yb == YLAST) ? DONE : DN_RD;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      xLat  <= '0;
      yTop  <= '0;
      yBot  <= '0;
    end else begin
      state <= stateNext;
      xLat  <= xNext;
      yTop  <= yTopNext;
      yBot  <= yBotNext;
    end
  end

  always_comb begin
    stateNext = state;
    xNext     = xLat;
    yTopNext  = yTop;
    yBotNext  = yBot;
    unique case (state)
      IDLE, DONE: begin
        if (bus.goMapRows) begin
          xNext    = bus.xStart;
          yTopNext = bus.yStart;
          yBotNext = bus.yStart;
          if (badSeed)
            stateNext = DONE;
          else if (bus.yStart == 3'd0)
            stateNext = downEntry(bus.yStart);
          else
            stateNext = UP_RD;
        end
      end
      UP_RD: stateNext = UP_CHK;
      UP_CHK: begin
        if (lit) begin
          yTopNext  = decTop;
          stateNext = (decTop != 3'd0) ? UP_RD
                                       : downEntry(yBot);
        end else begin
          stateNext = downEntry(yBot);
        end
      end
      DN_RD: stateNext = DN_CHK;
      DN_CHK: begin
        if (lit) begin
          yBotNext  = incBot;
          stateNext = (incBot < YLAST) ? DN_RD : DONE;
        end else begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    probeY = '0;
    unique case (1'b1)
      (state == UP_RD): probeY = decTop;
      (state == DN_RD): probeY = incBot;
      default:          probeY = '0;
    endcase
  end

  // y*6 + x as shift-and-add; max 5*6+5 = 35 fits 6 bits.
  assign rowAddr = {1'b0, probeY, 2'b00} +
                   {2'b00, probeY, 1'b0} +
                   {3'b000, xLat};

  assign found              = (state == DONE);
  assign bus.rdAddr         = (state == UP_RD || state == DN_RD)
                              ? rowAddr : '0;
  assign bus.yTop           = yTop;
  assign bus.yBottom        = yBot;
  assign bus.topBottomFound = found;
  assign bus.busy           = (state != IDLE) && (state != DONE);

`ifdef STAR_HEIGHT_EN
  assign bus.starHeight = found ? 3'(yBot - yTop + 3'd1) : 3'd0;
`endif

endmodule

// File: tb/tb_star_row_mapper.sv
// Directed bench for star_row_mapper: table of seed/column vectors with
// hand-computed per-cycle read addresses, spans and latencies.
module tb_star_row_mapper;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  star_row_mapper_if bus ();

  star_row_mapper #(
    .THRESHOLD(0),
    .MAX_X(6),
    .MAX_Y(6)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  logic [2:0] mem [0:63];
  always_ff @(posedge clk) bus.pixVal <= mem[bus.rdAddr];

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [5:0] mask;
    logic [2:0] top;
    logic [2:0] bot;
    int         cyc;
    logic [5:0] adr [12];
  } vec_t;

  vec_t vecs [9];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, " rdAddr"}, int'(bus.rdAddr), 0);
    chk({tag, " yTop"}, int'(bus.yTop), 0);
    chk({tag, " yBottom"}, int'(bus.yBottom), 0);
    chk({tag, " found"}, int'(bus.topBottomFound), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
  endtask

  // Background lit everywhere; column x follows mask (bit r = row r).
  task automatic loadCol(input logic [2:0] x, input logic [5:0] m);
    for (int i = 0; i < 64; i++) mem[i] = 3'd5;
    if (x < 3'd6)
      for (int r = 0; r < 6; r++)
        mem[r * 6 + int'(x)] = m[r] ? ((r % 2) ? 3'd7 : 3'd1)
                                    : 3'd0;
  endtask

  task automatic runVec(input int id, input int retrig,
                        input int rstAt);
    vec_t v;
    int   found;
    bit   adrOk;
    bit   busyOk;
    string t;
    v      = vecs[id];
    found  = 0;
    adrOk  = 1'b1;
    busyOk = 1'b1;
    t      = $sformatf("v%0d", id);
    loadCol(v.x, v.mask);
    bus.xStart    = v.x;
    bus.yStart    = v.y;
    bus.goMapRows = 1'b1;
    tick();
    bus.goMapRows = 1'b0;
    bus.xStart    = 3'd3;
    bus.yStart    = 3'd3;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      if (c == rstAt) begin
        resetn = 1'b0;
        #1;
        chkZero({t, " midreset"});
        resetn = 1'b1;
        return;
      end
      if (bus.topBottomFound) begin
        found = c;
      end else begin
        if (c > 12) adrOk = 1'b0;
        else if (bus.rdAddr !== v.adr[c-1]) adrOk = 1'b0;
        if (!bus.busy) busyOk = 1'b0;
        if (c == retrig) begin
          bus.goMapRows = 1'b1;
          bus.xStart    = 3'd0;
          bus.yStart    = 3'd0;
        end
        tick();
        bus.goMapRows = 1'b0;
      end
    end
    chk({t, " found cycle"}, found, v.cyc);
    chk({t, " addr seq ok"}, int'(adrOk), 1);
    chk({t, " busy in scan"}, int'(busyOk), 1);
    chk({t, " yTop"}, int'(bus.yTop), int'(v.top));
    chk({t, " yBottom"}, int'(bus.yBottom), int'(v.bot));
    chk({t, " busy done"}, int'(bus.busy), 0);
    chk({t, " rdAddr done"}, int'(bus.rdAddr), 0);
`ifdef STAR_HEIGHT_EN
    chk({t, " starHeight"}, int'(bus.starHeight),
        int'(v.bot) - int'(v.top) + 1);
`endif
  endtask

  initial begin
    vecs[0] = '{x:4, y:2, mask:6'b001110, top:1, bot:3, cyc:9,
      adr:'{10,0,4,0,22,0,28,0,0,0,0,0}};
    vecs[1] = '{x:0, y:0, mask:6'b111111, top:0, bot:5, cyc:11,
      adr:'{6,0,12,0,18,0,24,0,30,0,0,0}};
    vecs[2] = '{x:5, y:5, mask:6'b100000, top:5, bot:5, cyc:3,
      adr:'{29,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[3] = '{x:2, y:3, mask:6'b001000, top:3, bot:3, cyc:5,
      adr:'{14,0,26,0,0,0,0,0,0,0,0,0}};
    vecs[4] = '{x:1, y:5, mask:6'b111111, top:0, bot:5, cyc:11,
      adr:'{25,0,19,0,13,0,7,0,1,0,0,0}};
    vecs[5] = '{x:3, y:0, mask:6'b000001, top:0, bot:0, cyc:3,
      adr:'{9,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[6] = '{x:6, y:1, mask:6'b000000, top:1, bot:1, cyc:1,
      adr:'{0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[7] = '{x:2, y:7, mask:6'b000000, top:7, bot:7, cyc:1,
      adr:'{0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[8] = '{x:5, y:4, mask:6'b110000, top:4, bot:5, cyc:5,
      adr:'{23,0,35,0,0,0,0,0,0,0,0,0}};

    resetn        = 1'b0;
    bus.goMapRows = 1'b0;
    bus.xStart    = 3'd0;
    bus.yStart    = 3'd0;
    loadCol(3'd0, 6'b0);
    tick();
    tick();
    chkZero("reset");
`ifdef STAR_HEIGHT_EN
    chk("reset starHeight", int'(bus.starHeight), 0);
`endif
    resetn = 1'b1;
    tick();
    tick();
    chk("idle found", int'(bus.topBottomFound), 0);
    chk("idle busy", int'(bus.busy), 0);

    for (int i = 0; i < 9; i++) runVec(i, 0, 0);

    runVec(0, 3, 0);

    runVec(0, 0, 6);
    tick();
    tick();
    chk("post-reset idle found", int'(bus.topBottomFound), 0);
    chk("post-reset idle busy", int'(bus.busy), 0);
    chk("post-reset yTop", int'(bus.yTop), 0);
    runVec(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/star_row_mapper.md
STAR_ROW_MAPPER -- requirements
Module: star_row_mapper

Interface
REQ-001 SHALL have parameter THRESHOLD, default 0: a pixel is lit when pixVal > THRESHOLD.
REQ-002 SHALL have parameter MAX_X, default 6: image width in pixels.
REQ-003 SHALL have parameter MAX_Y, default 6: image height in pixels.
REQ-004 SHALL have port clk  in  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port goMapRows  in  1: one-cycle start pulse from the scan FSM.
REQ-007 SHALL have port xStart  in  3: column of the seed lit pixel.
REQ-008 SHALL have port yStart  in  3: row of the seed lit pixel.
REQ-009 SHALL have port pixVal  in  3: RAM read data, valid one cycle after rdAddr is presented.
REQ-010 SHALL have port rdAddr  out  6: RAM read address, yProbe*6 + xStart.
REQ-011 SHALL have port yTop  out  3: top-most contiguous lit row in column xStart.
REQ-012 SHALL have port yBottom  out  3: bottom-most contiguous lit row in column xStart.
REQ-013 SHALL have port topBottomFound  out  1: high when yTop/yBottom are valid.
REQ-014 SHALL have port busy  out  1: high while a mapping is in progress.

Function
REQ-015 SHALL implement the states IDLE, UP_RD, UP_CHK, DN_RD, DN_CHK and DONE.
REQ-016 SHALL, in IDLE or DONE, accept goMapRows=1: latch xStart/yStart, clear topBottomFound, set yTop=yBottom=yStart, and go to UP_RD, or to DN_RD if yStart==0, or to DONE if yStart==MAX_Y-1 too.
REQ-017 SHALL, in UP_RD, drive rdAddr for row yTop-1 and go to UP_CHK the next cycle.
REQ-018 SHALL, in UP_CHK, on a lit pixel decrement yTop, then go to UP_RD if the new yTop>0, else to DN_RD; on a dark pixel go to DN_RD.
REQ-019 SHALL, when entering DN_RD with yBottom==MAX_Y-1, skip directly to DONE.
REQ-020 SHALL, in DN_RD, drive rdAddr for row yBottom+1 and go to DN_CHK the next cycle.
REQ-021 SHALL, in DN_CHK, on a lit pixel increment yBottom, then go to DN_RD if the new yBottom<MAX_Y-1, else to DONE; on a dark pixel go to DONE.
REQ-022 SHALL hold topBottomFound high in DONE until the next accepted goMapRows or reset.
REQ-023 SHALL compute rdAddr as ({y,2'b0}+{y,1'b0}+x) zero-extended to 6 bits; rdAddr SHALL be 0 outside the RD states.
REQ-024 SHALL ignore goMapRows while busy; a mapping never restarts mid-scan.
REQ-025 SHALL, if xStart>=MAX_X or yStart>=MAX_Y, go straight to DONE with yTop=yBottom=yStart and issue no reads.
REQ-026 SHALL never probe the seed pixel itself; it is lit by definition.
REQ-027 SHALL take exactly 2*P+1 cycles from the goMapRows edge to topBottomFound=1, where P is the number of probes.
REQ-028 SHALL drive busy=1 in every state except IDLE and DONE.

Reset
REQ-029 SHALL, on resetn=0 at any time including mid-scan, enter IDLE with yTop=0, yBottom=0, topBottomFound=0, busy=0 and rdAddr=0.
REQ-030 SHALL require a fresh goMapRows after reset release; latched coordinates are discarded.

Configuration
REQ-031 SHALL, when macro STAR_HEIGHT_EN is defined, add output starHeight[2:0] = yBottom-yTop+1, valid while topBottomFound=1 and 0 otherwise.
REQ-032 SHALL, when STAR_HEIGHT_EN is undefined, have no starHeight port, with all other behaviour identical.

Verification
REQ-033 SHALL cover a mid-column star: lit rows 1-3 at x=4, go with (4,2) -> reads at addr 10, 4, 22, 28; yTop=1, yBottom=3; found at cycle 9.
REQ-034 SHALL cover top/bottom edges: full column x=0 lit, go with (0,0) -> no up reads; yTop=0, yBottom=5; found at cycle 11.
REQ-035 SHALL cover an isolated pixel: only (5,5) lit, go with (5,5) -> one up read at addr 29; yTop=yBottom=5; found at cycle 3.
REQ-036 SHALL cover re-trigger while busy: goMapRows pulsed again mid-scan -> ignored; result matches the single-go case.
REQ-037 SHALL cover mid-scan reset: resetn=0 during DN_CHK -> all outputs 0 immediately; the next go completes normally.
REQ-038 SHALL cover invalid coordinates with STAR_HEIGHT_EN: go with (6,1) -> no reads; found at cycle 1; yTop=yBottom=1, starHeight=1.
